// File: rtl/ed25519_point_encode.sv
`default_nettype none
// ============================================================================
// Module   : ed25519_point_encode
// Brief    : Projective (X:Y:Z) to affine conversion and RFC 8032 compression
//            for Ed25519; inverse via Z^(p-2) on one bit-serial multiplier.
//            Optional macro ED25519_ENC_PERF_EN adds the mul_count port.
// Revision : 1.0 - initial release
// ============================================================================
module ed25519_point_encode #(
  parameter int MUL_STEPS = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] P_X,
  input  logic [254:0] P_Y,
  input  logic [254:0] P_Z,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [254:0] A_X,
  output logic [254:0] A_Y,
  output logic [255:0] ENC
`ifdef ED25519_ENC_PERF_EN
  ,
  output logic [15:0]  mul_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INV  = 3'd2,
    S_MULX = 3'd3,
    S_MULY = 3'd4,
    S_PACK = 3'd5
  } state_t;

  localparam logic [255:0] c_p =
    256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
  localparam logic [254:0] c_e    = c_p[254:0] - 255'd2;
  localparam logic [7:0]   c_last = 8'(MUL_STEPS);

  function automatic logic [254:0] red1(input logic [255:0] v);
    logic [255:0] t;
    t = (v >= c_p) ? v - c_p : v;
    return t[254:0];
  endfunction

  state_t       state_q, state_d;
  logic [254:0] x_q, x_d, y_q, y_d, z_q, z_d, acc_q, acc_d;
  logic [254:0] a_sh_q, a_sh_d, b_q, b_d, r_q, r_d;
  logic [7:0]   cnt_q, cnt_d, idx_q, idx_d;
  logic         mulz_q, mulz_d, err_q, err_d;
  logic         done_q, done_d, errout_q, errout_d;
  logic [254:0] ax_q, ax_d, ay_q, ay_d;
  logic [255:0] enc_q, enc_d;

  logic [254:0] w_r2, w_r3, w_xr, w_yr, w_zr, w_op_a, w_op_b;
  logic         w_in_mul, w_last;

  // One shift-add iteration: r = 2r mod p, then r += b mod p when the bit is set.
  assign w_r2     = red1({r_q, 1'b0});
  assign w_r3     = red1({1'b0, w_r2} + (a_sh_q[254] ? {1'b0, b_q} : 256'd0));
  assign w_xr     = red1({1'b0, x_q});
  assign w_yr     = red1({1'b0, y_q});
  assign w_zr     = red1({1'b0, z_q});
  assign w_in_mul = (state_q == S_INV) || (state_q == S_MULX) || (state_q == S_MULY);
  assign w_last   = w_in_mul && (cnt_q == c_last);

  always_comb begin
    w_op_a = acc_q;
    w_op_b = acc_q;
    case (state_q)
      S_INV:   w_op_b = mulz_q ? z_q : acc_q;
      S_MULX:  w_op_a = x_q;
      S_MULY:  w_op_a = y_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mulz_d   = mulz_q;
    err_d    = err_q;
    done_d   = 1'b0;
    errout_d = errout_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    enc_d    = enc_q;

    if (w_in_mul) begin
      if (cnt_q == 8'd0) begin
        r_d    = '0;
        a_sh_d = w_op_a;
        b_d    = w_op_b;
        cnt_d  = 8'd1;
      end else begin
        r_d    = w_r3;
        a_sh_d = {a_sh_q[253:0], 1'b0};
        cnt_d  = w_last ? 8'd0 : cnt_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = P_X;
          y_d     = P_Y;
          z_d     = P_Z;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        x_d   = w_xr;
        y_d   = w_yr;
        z_d   = w_zr;
        cnt_d = 8'd0;
        if (w_zr == '0) begin
          err_d   = 1'b1;
          x_d     = '0;
          y_d     = '0;
          state_d = S_PACK;
        end else begin
          err_d   = 1'b0;
          acc_d   = w_zr;
          idx_d   = 8'd253;
          mulz_d  = 1'b0;
          state_d = S_INV;
        end
      end
      S_INV: begin
        if (w_last) begin
          acc_d = w_r3;
          // After a squaring, a set exponent bit schedules the multiply by Z.
          if (!mulz_q && c_e[idx_q]) begin
            mulz_d = 1'b1;
          end else begin
            mulz_d = 1'b0;
            if (idx_q == 8'd0) state_d = S_MULX;
            else               idx_d   = idx_q - 8'd1;
          end
        end
      end
      S_MULX: begin
        if (w_last) begin
          x_d     = w_r3;
          state_d = S_MULY;
        end
      end
      S_MULY: begin
        if (w_last) begin
          y_d     = w_r3;
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        ax_d     = x_q;
        ay_d     = y_q;
        enc_d    = {x_q[0], y_q};
        errout_d = err_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      mulz_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      errout_q <= 1'b0;
      ax_q     <= '0;
      ay_q     <= '0;
      enc_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mulz_q   <= mulz_d;
      err_q    <= err_d;
      done_q   <= done_d;
      errout_q <= errout_d;
      ax_q     <= ax_d;
      ay_q     <= ay_d;
      enc_q    <= enc_d;
    end
  end

`ifdef ED25519_ENC_PERF_EN
  logic [15:0] mc_q;

  always_ff @(posedge clk) begin
    if (rst)                              mc_q <= '0;
    else if (state_q == S_IDLE && start)  mc_q <= '0;
    else if (w_last)                      mc_q <= mc_q + 16'd1;
  end

  assign mul_count = mc_q;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = errout_q;
  assign A_X  = ax_q;
  assign A_Y  = ay_q;
  assign ENC  = enc_q;

endmodule
`default_nettype wire

// File: doc/ed25519_point_encode.md
Name: ed25519_point_encode

Overview:
- Consumer end of the scalar-multiplier result interface.
- Takes an extended-projective point (X:Y:Z) as produced by the ladder and converts it to affine x = X/Z, y = Y/Z mod p, where p = 2^255-19.
- Packs the RFC 8032 32-byte compressed encoding {x[0], y[254:0]}.
- Uses the same start-pulse / done-pulse handshake as the point units. One internal bit-serial modular multiplier computes the inverse as Z^(p-2), followed by two products.

Parameters:
- MUL_STEPS, 255: iterations per modular multiply. Fixed by the field width; not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- P_X  in  255  projective X (T coordinate not needed)
- P_Y  in  255  projective Y
- P_Z  in  255  projective Z
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start
- err  out  1  Z ≡ 0 mod p; valid with done
- A_X  out  255  affine x, canonical (< p)
- A_Y  out  255  affine y, canonical (< p)
- ENC  out  256  compressed encoding {A_X[0], A_Y}

Behaviour:
- Reset (rst high at a clk edge) forces the state to IDLE and clears busy, done, err, A_X, A_Y and ENC. If asserted mid-operation, all progress is discarded and no done is issued.
- States: IDLE, LOAD, INV, MULX, MULY, PACK.
- IDLE:
  - done is low except in the single cycle following PACK.
  - start=1 latches P_X, P_Y, P_Z and moves to LOAD.
  - start is also accepted in the cycle in which done is high.
- Any start while busy is ignored and does not disturb the operation.
- LOAD (1 cycle):
  - Reduce each input once: if v >= p then v-p, else v. Inputs are < 2^255, so one subtract suffices.
  - If the reduced Z == 0: set err, go to PACK with x = y = 0.
  - Otherwise set acc = Z and exponent index = 253, then go to INV.
- INV: left-to-right square-and-multiply over e = p-2 = 2^255-21.
  - acc starts at Z, which consumes bit 254.
  - For each bit i from 253 down to 0: acc = acc^2, then, if e[i] is 1, acc = acc·Z.
  - e has zeros only at bits 2 and 4. This gives 254 squarings + 252 multiplies = 506 products.
- MULX: x = X·inv. MULY: y = Y·inv.
- PACK (1 cycle): register A_X, A_Y, ENC = {x[0], y} and err. Pulse done for the next cycle and return to IDLE.
- Multiplier: interleaved MSB-first shift-add.
  - One load cycle, then 255 iterations: r = 2r mod p, then r += b mod p if the bit is set.
  - Conditional subtracts keep r in [0, p) at every step. Total 256 cycles per product.
- Latency, with cycle 0 being the cycle in which start is sampled:
  - Cycle 1: LOAD.
  - Cycles 2..130049: 508 products × 256 cycles.
  - Cycle 130050: PACK.
  - done is high in cycle 130051.
- Latency for the Z=0 path: LOAD in cycle 1, PACK in cycle 2, done in cycle 3.
- Latency is data-independent apart from the Z=0 case.
- All arithmetic is done in 256-bit intermediates. Outputs are always fully reduced.

Optional Feature:
- Macro ED25519_ENC_PERF_EN.
- When defined:
  - Adds output port mul_count [15:0].
  - It is cleared on the start-accept edge and incremented once per completed modular product.
  - It holds its value after done; the value is 508 normally and 0 for err.
- When undefined: the port and counter are absent, and timing is identical.

Test Plan:
- Identity point (0, 1, 1) → done in cycle 130051, err=0, A_X=0, A_Y=1, ENC=256'h1.
- Base point (Bx, By, 1), where By = 0x6666…6658 → ENC = 256'h6666666666666666666666666666666666666666666666666666666666666658, A_X=Bx.
  - Repeat with (2Bx, 2By, 2) mod p: identical ENC.
- Negated base point (p-Bx, By, 1) → ENC = 256'hE666666666666666666666666666666666666666666666666666666666666658, i.e. bit 255 set.
- Non-canonical input (0, 2^255-18, 1) → Y reduces to 1, so ENC=256'h1.
- Z = p (≡ 0) → err=1, A_X=A_Y=0, ENC=0, done in cycle 3.
- Protocol checks:
  - A second start pulse at cycle 1000 is ignored: a single done, at cycle 130051.
  - rst pulsed at cycle 5000 → busy=0 and no done.
  - A new start issued in the done cycle is accepted.
